// File: rtl/disp_pkg.sv
// Shared types and constants for the 7-segment scan driver: FSM states,
// all-off patterns and the active-low hex segment table (gfedcba).
package disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_e;

  localparam logic [6:0] SEG_OFF   = 7'b1111111;
  localparam logic [3:0] ANODE_OFF = 4'b1111;

  // Entry n is the pattern for hex digit n; index 0 sits in the low bits.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/seg_decoder.sv
// Combinational hex-to-7-segment decoder, active-low outputs {g,f,e,d,c,b,a}.
module seg_decoder
  import disp_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_LUT[hex_i];

endmodule

// File: rtl/digit_scanner.sv
// 4-digit multiplexed 7-segment driver: FSM and counters pick the digit and
// slot phase; a registered output stage turns that state into pins.
//
// Handshake: none. i_en is a level; while high the scan free-runs, and while
// low (or during i_rst) every output is held at its off/zero value.
module digit_scanner
  import disp_pkg::*;
#(
  parameter int DIV   = 8,
  parameter int BLANK = 2,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [8:0]       i_data,
  output logic [1:0]       o_ctrl,
  output logic [3:0]       o_anode,
  output logic [6:0]       o_seg,
  output logic             o_dp,
  output logic             o_frame,
  output logic [1:0]       o_dbg_state
);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DIV - BLANK - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       digit_q, digit_d;
  logic             wrap_q, wrap_d;

  logic [1:0]       ctrl_q, ctrl_d;
  logic [3:0]       anode_q, anode_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frame_q, frame_d;

  logic [6:0]       dec_seg;
  logic             unused_data;

  assign unused_data = ^i_data[8:5];

  seg_decoder u_seg_decoder (
    .hex_i (i_data[3:0]),
    .seg_o (dec_seg)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    digit_d = digit_q;
    wrap_d  = 1'b0;
    if (!i_en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      digit_d = 2'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          digit_d = 2'd0;
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_DRIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DRIVE: begin
          if (cnt_q == DRIVE_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            digit_d = digit_q + 2'd1;
            wrap_d  = (digit_q == 2'd3);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          digit_d = 2'd0;
        end
      endcase
    end
  end

  // Pins follow the FSM one edge later, so o_ctrl and the anodes always move
  // together and the anodes are already off when o_ctrl steps to a new digit.
  always_comb begin
    ctrl_d  = 2'd0;
    anode_d = ANODE_OFF;
    seg_d   = SEG_OFF;
    dp_d    = 1'b1;
    frame_d = 1'b0;
    if (i_en) begin
      ctrl_d  = digit_q;
      frame_d = wrap_q;
      if (state_q == ST_DRIVE) begin
        anode_d = ~(4'b0001 << digit_q);
        seg_d   = dec_seg;
        dp_d    = ~i_data[4];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      digit_q <= 2'd0;
      wrap_q  <= 1'b0;
      ctrl_q  <= 2'd0;
      anode_q <= ANODE_OFF;
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      wrap_q  <= wrap_d;
      ctrl_q  <= ctrl_d;
      anode_q <= anode_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      frame_q <= frame_d;
    end
  end

  assign o_ctrl      = ctrl_q;
  assign o_anode     = anode_q;
  assign o_seg       = seg_q;
  assign o_dp        = dp_q;
  assign o_frame     = frame_q;
  assign o_dbg_state = state_q;

endmodule

// File: doc/digit_scanner.md
# digit_scanner

Time-multiplexed 4-digit 7-segment display driver that sits directly downstream of the registered 4:1 digit `MUX`. It generates the `MUX` select, drives one-hot anode enables, decodes the selected digit into segment patterns, and inserts blanking between digits to prevent ghosting. It also covers the one-cycle `MUX` output latency.

## Interface

Parameters:
- `DIV`, 8: clock cycles per digit slot. Legal range is `DIV > BLANK`.
- `BLANK`, 2: dead cycles at the start of each slot with all anodes off. Legal range is `BLANK >= 2`.
- `CNT_W`, 16: width of the slot counter. Must hold `DIV-1`.

Ports:
- `i_clk`  in  1  — the single clock.
- `i_rst`  in  1  — reset. Synchronous, active-high.
- `i_en`  in  1  — scan enable, level-sensitive.
- `i_data`  in  9  — `MUX` `o_data`. Bits [3:0] are the hex digit, bit [4] is the decimal point, bits [8:5] are ignored.
- `o_ctrl`  out  2  — digit select. Connects to `MUX` `i_ctrl`.
- `o_anode`  out  4  — digit enables, active-low, one-hot-low. Bit n enables digit n.
- `o_seg`  out  7  — segments {g,f,e,d,c,b,a}, active-low.
- `o_dp`  out  1  — decimal point, active-low.
- `o_frame`  out  1  — one-cycle pulse when digit 3's slot completes.

## Operation

- States:
  - `IDLE`: all outputs are off.
  - `BLANK`: anodes are off and `o_ctrl` selects the current digit.
  - `DRIVE`: `o_anode[o_ctrl]` is low.
- Reset values:
  - state = `IDLE`, `cnt`=0
  - `o_ctrl`=0
  - `o_anode`=4'b1111, `o_seg`=7'b1111111, `o_dp`=1
  - `o_frame`=0
- Transitions out of `IDLE`: `i_en`=1 moves to `BLANK` with `o_ctrl`=0 and `cnt`=0.
- Transitions out of `BLANK`:
  - `cnt` counts 0..`BLANK`-1.
  - At `BLANK`-1 the block moves to `DRIVE` and clears `cnt`.
- Transitions out of `DRIVE`:
  - `cnt` counts 0..`DIV`-`BLANK`-1.
  - At the last count the block moves to `BLANK`, clears `cnt` and increments `o_ctrl` mod 4 (3 wraps to 0).
  - On the 3→0 wrap, `o_frame`=1 for exactly that cycle.
- `i_en`=0 in any state:
  - The block moves to `IDLE` at the next edge.
  - The outputs return to their reset values, including `o_ctrl`=0.
  - This takes priority over every other transition.
- `i_rst` has priority over `i_en`. Reset mid-`DRIVE` gives reset values at the next edge, with no partial frame pulse.
- Segment path:
  - `o_seg` and `o_dp` are registered from `i_data` every cycle while in `DRIVE`.
  - They are forced off in `IDLE` and `BLANK`.
  - `o_dp` = ~`i_data[4]`.
- Segment decode (active-low, gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.

## Timing

- All outputs are registered. There is no combinational path from input to output.
- Slot period is `DIV` cycles; frame period is 4·`DIV` cycles. Defaults give 8 and 32.
- `i_en` sampled high at edge T:
  - `BLANK` runs at edges T+1..T+`BLANK`.
  - `o_anode`=4'b1110 from edge T+1+`BLANK` for `DIV`-`BLANK` cycles.
- `MUX` latency: `o_ctrl` changes at the first `BLANK` edge, and `MUX` `o_data` follows one edge later. `BLANK>=2` guarantees `i_data` is stable before the first `DRIVE` edge, so no wrong-digit segments are ever lit.
- At most one anode is low at any time, and anodes are never low in the edge where `o_ctrl` changes.
- `o_frame` rises in the same cycle `o_ctrl` returns to 0.

## Structure

- Shared package `disp_pkg`:
  - state enum (`IDLE`/`BLANK`/`DRIVE`)
  - `SEG_OFF`=7'b1111111
  - `ANODE_OFF`=4'b1111
  - the 16-entry segment LUT constant
- Sub-module `seg_decoder`: combinational, 4-bit hex in, 7-bit active-low segments out, built from the package LUT. It is instantiated once in the registered segment path.
- The top level holds the FSM, the slot counter and the digit counter.

## Test plan

All scenarios use `DIV`=8, `BLANK`=2, with a real `MUX` instance fed `i_data_0..3`=1,2,3,4.
- Reset held for 4 cycles with `i_en`=1 → `o_anode`=1111, `o_seg`=1111111, `o_ctrl`=0 and `o_frame`=0 throughout.
- Release reset → 2 cycles of blank, then `o_anode`=1110 with `o_seg`=1111001 for 6 cycles, then 2 blank cycles with `o_ctrl`=1, then `o_anode`=1101 with `o_seg`=0100100. Digits 3 and 4 show 0110000 and 0011001.
- Free-run for 3 frames → `o_frame` pulses every 32 cycles, coincident with the 3→0 wrap. Anodes never have more than one bit low, and are never low on an `o_ctrl` change edge.
- Drop `i_en` at `DRIVE` cycle 3 of digit 2 → next edge gives all-off outputs and `o_ctrl`=0. Re-assert → the scan restarts at digit 0 after 2 blank cycles.
- Assert `i_rst` mid-`DRIVE` of digit 3 → reset values next edge with no `o_frame` pulse. Release → the scan restarts at digit 0.
- `i_data_1`=9'h01F (dp=1, F) → digit 1 shows `o_seg`=0001110 and `o_dp`=0; the other digits show `o_dp`=1.
